// File: rtl/regfile_2w2r_sb_if.sv
// Purpose: bundles the read, write and reserve signals of regfile_2w2r_sb.
// Latency: not applicable; this is wiring only.
// Backpressure: none. Every write and reservation is accepted every cycle.
// Ports: rd_addr1/2 -> rd_data1/2 and rd_busy1/2; wr_en/addr/data for ports 0 and 1; rsv_en/rsv_addr.
// The master modport drives addresses, writes and reservations. The slave modport returns read data and busy.
interface regfile_2w2r_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_data0;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data1;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  modport master (
    output rd_addr1, rd_addr2,
    output wr_en0, wr_addr0, wr_data0,
    output wr_en1, wr_addr1, wr_data1,
    output rsv_en, rsv_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2
  );

  modport slave (
    input  rd_addr1, rd_addr2,
    input  wr_en0, wr_addr0, wr_data0,
    input  wr_en1, wr_addr1, wr_data1,
    input  rsv_en, rsv_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2
  );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Purpose: a register file with 2 write ports and 2 read ports, plus a per-entry busy scoreboard.
// Latency: reads take 1 cycle. Same-edge writes and reservations are bypassed into the read result.
// Backpressure: none. All writes and reservations are accepted every cycle.
// Ports: clk and rst (synchronous, active-low) are scalar ports.
// The bus port (slave modport) carries rd_addr/rd_data/rd_busy for reads 1 and 2, writes 0 and 1, and rsv.
// Write port 1 wins an address conflict. With ZERO_REG=1, entry 0 reads as 0 and is never busy.
module regfile_2w2r_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_2w2r_sb_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] mem_nxt  [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // Next-state view of every entry. The read ports sample this view,
  // so a read always returns the post-edge contents (bypass) for free.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i]  = mem[i];
      busy_nxt[i] = busy[i];
      if (bus.wr_en0 && bus.wr_addr0 == ADDR_W'(i)) begin
        mem_nxt[i]  = bus.wr_data0;
        busy_nxt[i] = 1'b0;
      end
      // Port 1 is evaluated second so that it overrides port 0.
      if (bus.wr_en1 && bus.wr_addr1 == ADDR_W'(i)) begin
        mem_nxt[i]  = bus.wr_data1;
        busy_nxt[i] = 1'b0;
      end
      // A reservation on the same edge as a completing write is a newer
      // producer than that write, so the reservation wins.
      if (bus.rsv_en && bus.rsv_addr == ADDR_W'(i)) begin
        busy_nxt[i] = 1'b1;
      end
      if (ZERO_REG && i == 0) begin
        mem_nxt[i]  = '0;
        busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy         <= '0;
      bus.rd_data1 <= '0;
      bus.rd_data2 <= '0;
      bus.rd_busy1 <= 1'b0;
      bus.rd_busy2 <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_nxt[i];
      end
      busy         <= busy_nxt;
      bus.rd_data1 <= mem_nxt[bus.rd_addr1];
      bus.rd_data2 <= mem_nxt[bus.rd_addr2];
      bus.rd_busy1 <= busy_nxt[bus.rd_addr1];
      bus.rd_busy2 <= busy_nxt[bus.rd_addr2];
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Purpose: checks three register-file configurations (16x16 with zero reg, 16x16 without, 32x32 with zero reg).
// Latency: every stimulus cycle queues one expected read result per instance, to be compared after the next edge.
// Backpressure: none. The stimulus runs free and the monitor drains the queues.
module tb_regfile_2w2r_sb;

  typedef struct packed {
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        s_we0 = 1'b0, s_we1 = 1'b0, s_rsv = 1'b0;
  logic [4:0]  s_wa0 = '0, s_wa1 = '0, s_rsva = '0, s_ra1 = '0, s_ra2 = '0;
  logic [31:0] s_wd0 = '0, s_wd1 = '0;

  regfile_2w2r_sb_if #(.DATA_W(16), .ADDR_W(4)) if_a ();
  regfile_2w2r_sb_if #(.DATA_W(16), .ADDR_W(4)) if_b ();
  regfile_2w2r_sb_if #(.DATA_W(32), .ADDR_W(5)) if_c ();

  regfile_2w2r_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  regfile_2w2r_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.rd_addr1 = s_ra1[3:0];  assign if_b.rd_addr1 = s_ra1[3:0];  assign if_c.rd_addr1 = s_ra1;
  assign if_a.rd_addr2 = s_ra2[3:0];  assign if_b.rd_addr2 = s_ra2[3:0];  assign if_c.rd_addr2 = s_ra2;
  assign if_a.wr_en0   = s_we0;       assign if_b.wr_en0   = s_we0;       assign if_c.wr_en0   = s_we0;
  assign if_a.wr_addr0 = s_wa0[3:0];  assign if_b.wr_addr0 = s_wa0[3:0];  assign if_c.wr_addr0 = s_wa0;
  assign if_a.wr_data0 = s_wd0[15:0]; assign if_b.wr_data0 = s_wd0[15:0]; assign if_c.wr_data0 = s_wd0;
  assign if_a.wr_en1   = s_we1;       assign if_b.wr_en1   = s_we1;       assign if_c.wr_en1   = s_we1;
  assign if_a.wr_addr1 = s_wa1[3:0];  assign if_b.wr_addr1 = s_wa1[3:0];  assign if_c.wr_addr1 = s_wa1;
  assign if_a.wr_data1 = s_wd1[15:0]; assign if_b.wr_data1 = s_wd1[15:0]; assign if_c.wr_data1 = s_wd1;
  assign if_a.rsv_en   = s_rsv;       assign if_b.rsv_en   = s_rsv;       assign if_c.rsv_en   = s_rsv;
  assign if_a.rsv_addr = s_rsva[3:0]; assign if_b.rsv_addr = s_rsva[3:0]; assign if_c.rsv_addr = s_rsva;

  // Reference model: per-instance arrays, updated by applying the rules in order.
  int          aw    [3] = '{4, 4, 5};
  int          zr    [3] = '{1, 0, 1};
  logic [31:0] dmask [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};
  logic [31:0] m_mem [3][32];
  bit          m_busy[3][32];

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
  end

  task automatic step(input bit r,
                      input bit we0, input logic [4:0] wa0, input logic [31:0] wd0,
                      input bit we1, input logic [4:0] wa1, input logic [31:0] wd1,
                      input bit rsv, input logic [4:0] rsva,
                      input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    rst = r; s_we0 = we0; s_wa0 = wa0; s_wd0 = wd0;
    s_we1 = we1; s_wa1 = wa1; s_wd1 = wd1;
    s_rsv = rsv; s_rsva = rsva; s_ra1 = ra1; s_ra2 = ra2;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      int n, a0, a1, ar, r1, r2;
      n  = 1 << aw[k];
      a0 = int'(wa0) % n;  a1 = int'(wa1) % n;  ar = int'(rsva) % n;
      r1 = int'(ra1) % n;  r2 = int'(ra2) % n;
      e  = '0;
      if (!r) begin
        for (int i = 0; i < 32; i++) begin
          m_mem[k][i]  = '0;
          m_busy[k][i] = 1'b0;
        end
      end else begin
        if (we0 && !(zr[k] == 1 && a0 == 0)) begin
          m_mem[k][a0] = wd0 & dmask[k];
          m_busy[k][a0] = 1'b0;
        end
        if (we1 && !(zr[k] == 1 && a1 == 0)) begin
          m_mem[k][a1] = wd1 & dmask[k];
          m_busy[k][a1] = 1'b0;
        end
        if (rsv && !(zr[k] == 1 && ar == 0)) m_busy[k][ar] = 1'b1;
        e.d1 = m_mem[k][r1];  e.b1 = m_busy[k][r1];
        e.d2 = m_mem[k][r2];  e.b2 = m_busy[k][r2];
      end
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic rd(input logic [4:0] ra1, input logic [4:0] ra2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2);
  endtask

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got d1=%h b1=%b d2=%h b2=%b expected d1=%h b1=%b d2=%h b2=%b",
               name, $time, act.d1, act.b1, act.d2, act.b2, exp.d1, exp.b1, exp.d2, exp.b2);
    end
  endtask

  // Monitor: the outputs are registered, so results are sampled just after each rising edge.
  initial begin
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        act = {32'(if_a.rd_data1), if_a.rd_busy1, 32'(if_a.rd_data2), if_a.rd_busy2};
        compare("zr1_16x16", act, q0.pop_front());
      end
      if (q1.size() > 0) begin
        act = {32'(if_b.rd_data1), if_b.rd_busy1, 32'(if_b.rd_data2), if_b.rd_busy2};
        compare("zr0_16x16", act, q1.pop_front());
      end
      if (q2.size() > 0) begin
        act = {if_c.rd_data1, if_c.rd_busy1, if_c.rd_data2, if_c.rd_busy2};
        compare("zr1_32x32", act, q2.pop_front());
      end
    end
  end

  initial begin
    // Preload every entry with all-ones and mark it busy. Each read targets the entry being written.
    for (int a = 0; a < 32; a++)
      step(1, 1, 5'(a), 32'hFFFFFFFF, 0, 0, 0, 1, 5'(a), 5'(a), 5'(a));
    // The reset edge ignores the writes and reservations presented with it.
    step(0, 1, 5'd3, 32'h0123, 1, 5'd4, 32'h0055, 1, 5'd6, 5'd3, 5'd6);
    for (int a = 0; a < 32; a++) rd(5'(a), 5'((a + 1) % 32));

    // Basic write, then a read one edge later.
    step(1, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 5'd0, 5'd1);
    rd(5'd5, 5'd5);
    // Same-edge bypass from write port 1.
    step(1, 0, 0, 0, 1, 5'd7, 32'hBEEF, 0, 0, 5'd7, 5'd5);
    // Port priority on an address conflict, bypassed and then read back.
    step(1, 1, 5'd3, 32'hAAAA, 1, 5'd3, 32'h5555, 0, 0, 5'd7, 5'd3);
    rd(5'd3, 5'd3);
    // Entry 0: zero register in two instances, ordinary register in the third.
    step(1, 1, 5'd0, 32'h9999, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    rd(5'd0, 5'd3);
    // Scoreboard: reserve, complete the write three cycles later, then reserve and write on the same edge.
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    rd(5'd9, 5'd0);
    rd(5'd9, 5'd0);
    step(1, 1, 5'd9, 32'h0042, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    rd(5'd9, 5'd9);
    step(1, 0, 0, 0, 1, 5'd9, 32'h0077, 1, 5'd9, 5'd9, 5'd9);
    rd(5'd9, 5'd9);
    // Top address of the wide instance must not alias entry 15.
    step(1, 1, 5'd15, 32'h11111111, 0, 0, 0, 0, 0, 5'd15, 5'd15);
    step(1, 0, 0, 0, 1, 5'd31, 32'hDEADBEEF, 0, 0, 5'd31, 5'd15);
    rd(5'd31, 5'd15);

    // Random traffic, with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom), 5'($urandom), $urandom,
           1'($urandom), 5'($urandom), $urandom,
           1'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom));
    end
    rd(5'd0, 5'd31);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
